clkdiv_prog: RTL and testbench

//  Programmable clock divider for the video/pixel path. Next generation of the fixed

---
 rtl/clkdiv_prog.sv | 115 +++++++++++
 tb/tb_clkdiv_prog.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/clkdiv_prog.sv
// Purpose : programmable clock divider with glitch-free, period-aligned ratio reload.
// Latency : 1 clk from an enabled edge to dclk/tick; a ratio loads at the next period boundary.
// Backpressure: none; en low freezes the divider and keeps any pending load.
//
// Ports:
//   clk, rst          master clock, asynchronous active-high reset
//   en                count enable (low = freeze, tick forced low)
//   restart           synchronous phase restart pulse
//   div_load, div_val ratio load request; values below 2 are treated as 2
//   div_ack           one-cycle pulse when a loaded ratio takes effect
//   cur_div           ratio currently in use
//   dclk, tick        divided clock and one-cycle pulse on each dclk rising edge
module clkdiv_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_val,
    output logic             div_ack,
    output logic [WIDTH-1:0] cur_div,
    output logic             dclk,
    output logic             tick
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    logic [WIDTH-1:0] cnt, div_cur, pend_val;
    logic             pend;

    logic [WIDTH-1:0] cnt_n, div_n, pend_val_n, load_clamped;
    logic             pend_n, dclk_n, tick_n, ack_n, terminal;

    always_comb begin
        load_clamped = (div_val < TWO) ? TWO : div_val;
        terminal     = (cnt == div_cur - ONE);

        cnt_n      = cnt;
        div_n      = div_cur;
        pend_n     = pend;
        pend_val_n = pend_val;
        dclk_n     = dclk;
        tick_n     = 1'b0;
        ack_n      = 1'b0;

        // Capture is independent of en; a later request overwrites an earlier one.
        if (div_load) begin
            pend_n     = 1'b1;
            pend_val_n = load_clamped;
        end

        if (restart) begin
            // A same-cycle load bypasses the pending register.
            if (div_load) begin
                div_n  = load_clamped;
                ack_n  = 1'b1;
                pend_n = 1'b0;
            end else if (pend) begin
                div_n  = pend_val;
                ack_n  = 1'b1;
                pend_n = 1'b0;
            end
            // Parking on the terminal count makes the next enabled edge open a period.
            cnt_n  = div_n - ONE;
            dclk_n = 1'b0;
        end else if (en) begin
            if (terminal) begin
                cnt_n  = '0;
                tick_n = 1'b1;
                // Ratio changes only here, so the new period is always whole.
                if (div_load) begin
                    div_n  = load_clamped;
                    ack_n  = 1'b1;
                    pend_n = 1'b0;
                end else if (pend) begin
                    div_n  = pend_val;
                    ack_n  = 1'b1;
                    pend_n = 1'b0;
                end
            end else begin
                cnt_n = cnt + ONE;
            end
            // dclk is registered from the count it will sit at, so it is high for cnt < half.
            dclk_n = (cnt_n < (div_n >> 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= DIV_RST - ONE;
            div_cur  <= DIV_RST;
            pend     <= 1'b0;
            pend_val <= '0;
            dclk     <= 1'b0;
            tick     <= 1'b0;
            div_ack  <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            div_cur  <= div_n;
            pend     <= pend_n;
            pend_val <= pend_val_n;
            dclk     <= dclk_n;
            tick     <= tick_n;
            div_ack  <= ack_n;
        end
    end

    assign cur_div = div_cur;

endmodule

// File: tb/tb_clkdiv_prog.sv
module tb_clkdiv_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       restart = 1'b0;
    logic       div_load = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic       div_ack;
    logic [7:0] cur_div;
    logic       dclk;
    logic       tick;

    clkdiv_prog #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
        .clk(clk), .rst(rst), .en(en), .restart(restart),
        .div_load(div_load), .div_val(div_val), .div_ack(div_ack),
        .cur_div(cur_div), .dclk(dclk), .tick(tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       d;
        logic       t;
        logic       a;
        logic [7:0] c;
        string      nm;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passes = 0;

    task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got {dclk,tick,ack,cur}=%b_%b_%b_%0d expected %b_%b_%b_%0d",
                      nm, act[10], act[9], act[8], act[7:0], exp[10], exp[9], exp[8], exp[7:0]);
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic vec(input logic e, input logic rs, input logic ld, input logic [7:0] v,
                       input logic xd, input logic xt, input logic xa, input logic [7:0] xc,
                       input string nm);
        exp_t x;
        en = e; restart = rs; div_load = ld; div_val = v;
        x.cyc = cyc + 1; x.d = xd; x.t = xt; x.a = xa; x.c = xc; x.nm = nm;
        q.push_back(x);
        @(posedge clk); #2;
    endtask

    // Monitor: compares queued expectations against outputs at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++;
                $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.nm, e.cyc, cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                check(e.nm, {dclk, tick, div_ack, cur_div}, {e.d, e.t, e.a, e.c});
            end
        end
    end

    initial begin
        int c;
        // Reset values while rst is high
        #1 rst = 1'b1;
        #1 check("reset_state", {dclk, tick, div_ack, cur_div}, {1'b0, 1'b0, 1'b0, 8'd2});
        @(posedge clk); #2;
        rst = 1'b0;

        // 1: default divide-by-2, first tick one clk after reset release
        for (int i = 0; i < 9; i++)
            vec(1, 0, 0, 8'd0, (i % 2 == 0), (i % 2 == 0), 0, 8'd2, "t1_div2");

        // 2: load 5 mid-period, applies at the next terminal edge
        vec(1, 0, 1, 8'd5, 0, 0, 0, 8'd2, "t2_load5");
        vec(1, 0, 0, 8'd0, 1, 1, 1, 8'd5, "t2_apply5");
        for (int i = 1; i <= 10; i++) begin
            c = i % 5;
            vec(1, 0, 0, 8'd0, (c < 2), (c == 0), 0, 8'd5, "t2_div5");
        end

        // 3: 7 then 4 in one period, only 4 applies; then a bypass load of 0 clamps to 2
        vec(1, 0, 1, 8'd7, 1, 0, 0, 8'd5, "t3_load7");
        vec(1, 0, 1, 8'd4, 0, 0, 0, 8'd5, "t3_load4");
        vec(1, 0, 0, 8'd0, 0, 0, 0, 8'd5, "t3_wait");
        vec(1, 0, 0, 8'd0, 0, 0, 0, 8'd5, "t3_wait");
        vec(1, 0, 0, 8'd0, 1, 1, 1, 8'd4, "t3_apply4");
        for (int i = 1; i <= 7; i++) begin
            c = i % 4;
            vec(1, 0, 0, 8'd0, (c < 2), (c == 0), 0, 8'd4, "t3_div4");
        end
        vec(1, 0, 1, 8'd0, 1, 1, 1, 8'd2, "t3_bypass_clamp0");
        vec(1, 0, 0, 8'd0, 0, 0, 0, 8'd2, "t3_div2");
        vec(1, 0, 0, 8'd0, 1, 1, 0, 8'd2, "t3_div2");

        // 4: en low for 3 cycles mid-period at DIV=4 stretches the period by 3
        vec(1, 0, 1, 8'd4, 0, 0, 0, 8'd2, "t4_load4");
        vec(1, 0, 0, 8'd0, 1, 1, 1, 8'd4, "t4_apply4");
        vec(1, 0, 0, 8'd0, 1, 0, 0, 8'd4, "t4_cnt1");
        for (int i = 0; i < 3; i++)
            vec(0, 0, 0, 8'd0, 1, 0, 0, 8'd4, "t4_frozen");
        vec(1, 0, 0, 8'd0, 0, 0, 0, 8'd4, "t4_resume");
        vec(1, 0, 0, 8'd0, 0, 0, 0, 8'd4, "t4_resume");
        vec(1, 0, 0, 8'd0, 1, 1, 0, 8'd4, "t4_tick_late");

        // 5: restart at cnt=1 with DIV=6 and a same-cycle load of 3
        vec(1, 0, 1, 8'd6, 1, 0, 0, 8'd4, "t5_load6");
        vec(1, 0, 0, 8'd0, 0, 0, 0, 8'd4, "t5_wait");
        vec(1, 0, 0, 8'd0, 0, 0, 0, 8'd4, "t5_wait");
        vec(1, 0, 0, 8'd0, 1, 1, 1, 8'd6, "t5_apply6");
        vec(1, 0, 0, 8'd0, 1, 0, 0, 8'd6, "t5_cnt1");
        vec(1, 1, 1, 8'd3, 0, 0, 1, 8'd3, "t5_restart");
        vec(1, 0, 0, 8'd0, 1, 1, 0, 8'd3, "t5_first_tick");
        for (int i = 1; i <= 3; i++) begin
            c = i % 3;
            vec(1, 0, 0, 8'd0, (c < 1), (c == 0), 0, 8'd3, "t5_div3");
        end

        // 6: async reset with a load pending at DIV=8
        vec(1, 0, 1, 8'd8, 0, 0, 0, 8'd3, "t6_load8");
        vec(1, 0, 0, 8'd0, 0, 0, 0, 8'd3, "t6_wait");
        vec(1, 0, 0, 8'd0, 1, 1, 1, 8'd8, "t6_apply8");
        vec(1, 0, 0, 8'd0, 1, 0, 0, 8'd8, "t6_cnt1");
        vec(1, 0, 1, 8'd5, 1, 0, 0, 8'd8, "t6_pend5");
        @(negedge clk); #1;
        rst = 1'b1;
        #1 check("t6_async_reset", {dclk, tick, div_ack, cur_div}, {1'b0, 1'b0, 1'b0, 8'd2});
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++)
            vec(1, 0, 0, 8'd0, (i % 2 == 0), (i % 2 == 0), 0, 8'd2, "t6_no_stale_ack");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
